c2sif_arbiter: RTL and testbench

- Shares one C2S packet channel (4-phase req/ack, id/fn/addr/data/ret) between NUM_REQ requester ports.
- Requesters are RTL-side masters, e.g. bus-functional models or DMA stubs.
- The single downstream port drives the C-side responder.
- Round-robin arbitration, one packet in flight at a time, and full 4-phase relay on both sides.

---
 rtl/c2sif_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_c2sif_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2sif_arbiter.sv
// c2sif_arbiter: round-robin arbiter that shares one C2S 4-phase packet
// channel between NUM_REQ requesters, one packet in flight at a time.
// Optional build macro C2SIF_ARB_TIMEOUT_EN aborts a packet whose s_ack does
// not arrive within TIMEOUT_CYCLES and raises a sticky timeout_err.
module c2sif_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_SIZE      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            m_req,
  output logic [NUM_REQ-1:0]            m_ack,
  input  logic [NUM_REQ*32-1:0]         m_id,
  input  logic [NUM_REQ*32-1:0]         m_fn,
  input  logic [NUM_REQ*32-1:0]         m_addr,
  input  logic [NUM_REQ*DATA_SIZE*32-1:0] m_wdata,
  output logic [DATA_SIZE*32-1:0]       m_rdata,
  output logic [31:0]                   m_ret,
  output logic                          s_req,
  input  logic                          s_ack,
  output logic [31:0]                   s_id,
  output logic [31:0]                   s_fn,
  output logic [31:0]                   s_addr,
  output logic [DATA_SIZE*32-1:0]       s_wdata,
  input  logic [DATA_SIZE*32-1:0]       s_rdata,
  input  logic [31:0]                   s_ret,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned DW    = DATA_SIZE * 32;

  // Reject configurations outside the supported range at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("c2sif_arbiter: unsupported parameter values");
  end

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t               state, state_n;
  logic [IDX_W-1:0]     ptr, ptr_n;
  logic [IDX_W-1:0]     grant_n;
  logic [NUM_REQ-1:0]   ack_n;
  logic                 s_req_n, busy_n;
  logic [31:0]          id_n, fn_n, addr_n, ret_n;
  logic [DW-1:0]        wdata_n, rdata_n;
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx, cand;
`ifdef C2SIF_ARB_TIMEOUT_EN
  logic [31:0]          cnt, cnt_n;
  logic                 terr_n;
`endif

  // Round-robin pick: first requesting port at or after the pointer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!win_vld && m_req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and next-output logic for the relay FSM.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant_idx;
    ack_n   = m_ack;
    s_req_n = s_req;
    busy_n  = busy;
    id_n    = s_id;
    fn_n    = s_fn;
    addr_n  = s_addr;
    wdata_n = s_wdata;
    rdata_n = m_rdata;
    ret_n   = m_ret;
`ifdef C2SIF_ARB_TIMEOUT_EN
    cnt_n   = cnt;
    terr_n  = timeout_err;
`endif
    case (state)
      IDLE: begin
        // A lingering s_ack from the responder blocks a new grant.
        if (win_vld && !s_ack) begin
          state_n = REQ;
          grant_n = win_idx;
          s_req_n = 1'b1;
          busy_n  = 1'b1;
          id_n    = m_id[32'(win_idx)*32 +: 32];
          fn_n    = m_fn[32'(win_idx)*32 +: 32];
          addr_n  = m_addr[32'(win_idx)*32 +: 32];
          wdata_n = m_wdata[32'(win_idx)*DW +: DW];
`ifdef C2SIF_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      REQ: begin
`ifdef C2SIF_ARB_TIMEOUT_EN
        cnt_n = cnt + 32'd1;
`endif
        if (s_ack) begin
          state_n = RELEASE;
          s_req_n = 1'b0;
          ack_n   = NUM_REQ'(1) << grant_idx;
          rdata_n = s_rdata;
          ret_n   = s_ret;
        end
`ifdef C2SIF_ARB_TIMEOUT_EN
        else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          state_n = RELEASE;
          s_req_n = 1'b0;
          ack_n   = NUM_REQ'(1) << grant_idx;
          rdata_n = '0;
          ret_n   = 32'hFFFF_FFFF;
          terr_n  = 1'b1;
        end
`endif
      end
      RELEASE: begin
        // Both handshakes must be back to zero, in any order.
        if (!m_req[grant_idx] && !s_ack) begin
          state_n = IDLE;
          ack_n   = '0;
          busy_n  = 1'b0;
          ptr_n   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      m_ack     <= '0;
      s_req     <= 1'b0;
      busy      <= 1'b0;
      s_id      <= '0;
      s_fn      <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      m_rdata   <= '0;
      m_ret     <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_idx <= grant_n;
      m_ack     <= ack_n;
      s_req     <= s_req_n;
      busy      <= busy_n;
      s_id      <= id_n;
      s_fn      <= fn_n;
      s_addr    <= addr_n;
      s_wdata   <= wdata_n;
      m_rdata   <= rdata_n;
      m_ret     <= ret_n;
    end
  end

`ifdef C2SIF_ARB_TIMEOUT_EN
  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      timeout_err <= terr_n;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_c2sif_arbiter.sv
// tb_c2sif_arbiter: randomized scoreboard bench for c2sif_arbiter.
module tb_c2sif_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DS = 4;
  localparam int unsigned DW = DS * 32;
`ifdef C2SIF_ARB_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        m_req, m_ack;
  logic [N*32-1:0]     m_id, m_fn, m_addr;
  logic [N*DW-1:0]     m_wdata;
  logic [DW-1:0]       m_rdata, s_wdata, s_rdata;
  logic [31:0]         m_ret, s_id, s_fn, s_addr, s_ret;
  logic                s_req, s_ack, busy, timeout_err;
  logic [1:0]          grant_idx;
  logic                resp_ack, stale_ack, resp_en;

  assign s_ack = resp_ack | stale_ack;

  c2sif_arbiter #(.NUM_REQ(N), .DATA_SIZE(DS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_ack(m_ack), .m_id(m_id), .m_fn(m_fn),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ret(m_ret),
    .s_req(s_req), .s_ack(s_ack), .s_id(s_id), .s_fn(s_fn), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ret(s_ret), .grant_idx(grant_idx),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] id;
    logic [31:0] fn;
    logic [31:0] addr;
    logic [DW-1:0] wdata;
  } hdr_t;
  typedef struct {
    logic [DW-1:0] rdata;
    logic [31:0]   ret;
  } rsp_t;

  hdr_t hdr_q[$];
  int   ack_q[$];
  rsp_t rsp_q[$];
  rsp_t plan_q[$];

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;

  logic [31:0]   pay_id[N], pay_fn[N], pay_addr[N];
  logic [DW-1:0] pay_wd[N];
  int            cd[N];

  logic          mon_prev_sreq;
  logic [N-1:0]  mon_prev_ack;

  function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // One cycle; requesters drop m_req a random delay after seeing their m_ack.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (m_req[i] && m_ack[i]) begin
        if (cd[i] <= 0) m_req[i] = 1'b0;
        else cd[i]--;
      end
    end
  endtask

  task automatic rand_payload(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        pay_id[i]   = $urandom;
        pay_fn[i]   = $urandom;
        pay_addr[i] = $urandom;
        for (int w = 0; w < DS; w++) pay_wd[i][32*w +: 32] = $urandom;
      end
    end
  endtask

  // Reference model: a batch of simultaneous requests is served in
  // round-robin order starting at the pointer; pointer lands after the last.
  task automatic plan(input logic [N-1:0] mask, input bit expect_ack);
    int last;
    int i;
    last = ptr_m;
    for (int k = 0; k < N; k++) begin
      i = (ptr_m + k) % N;
      if (mask[i]) begin
        hdr_q.push_back('{i, pay_id[i], pay_fn[i], pay_addr[i], pay_wd[i]});
        if (expect_ack) ack_q.push_back(i);
        last = i;
      end
    end
    ptr_m = (last + 1) % N;
  endtask

  task automatic raise(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        m_id[32*i +: 32]   = pay_id[i];
        m_fn[32*i +: 32]   = pay_fn[i];
        m_addr[32*i +: 32] = pay_addr[i];
        m_wdata[DW*i +: DW] = pay_wd[i];
        cd[i]              = $urandom_range(0, 2);
        m_req[i]           = 1'b1;
      end
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((m_req != '0 || busy) && g < 500) begin
      step();
      g++;
    end
    check(name, DW'(m_req == '0 && !busy), DW'(1));
  endtask

  task automatic batch(input logic [N-1:0] mask);
    rand_payload(mask);
    plan(mask, 1'b1);
    raise(mask);
    step();
    check("req_latency", DW'(s_req), DW'(1));
    drain("batch_done");
  endtask

  // Responder: answers s_req after a random delay, releases s_ack late.
  initial begin
    int   g;
    rsp_t r;
    resp_ack = 1'b0;
    s_rdata  = '0;
    s_ret    = '0;
    forever begin
      @(negedge clk);
      if (resp_en && s_req && !resp_ack) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (resp_en && s_req && !rst) begin
          if (plan_q.size() > 0) r = plan_q.pop_front();
          else begin
            r.ret = $urandom;
            for (int w = 0; w < DS; w++) r.rdata[32*w +: 32] = $urandom;
          end
          s_rdata  = r.rdata;
          s_ret    = r.ret;
          resp_ack = 1'b1;
          rsp_q.push_back(r);
          g = 0;
          while (s_req && g < 200) begin
            @(negedge clk);
            g++;
          end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          resp_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: compares each grant and each acknowledge against the scoreboard.
  initial begin
    hdr_t h;
    rsp_t r;
    int   idx;
    mon_prev_sreq = 1'b0;
    mon_prev_ack  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_sreq = 1'b0;
        mon_prev_ack  = '0;
      end else begin
        check("ack_onehot0", DW'($onehot0(m_ack)), DW'(1));
        if (s_req && !mon_prev_sreq) begin
          if (hdr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_unexpected: got grant_idx %0d expected no grant", grant_idx);
          end else begin
            h = hdr_q.pop_front();
            check("grant_idx", DW'(grant_idx), DW'(h.idx));
            check("s_id", DW'(s_id), DW'(h.id));
            check("s_fn", DW'(s_fn), DW'(h.fn));
            check("s_addr", DW'(s_addr), DW'(h.addr));
            check("s_wdata", s_wdata, h.wdata);
            check("busy_in_req", DW'(busy), DW'(1));
          end
        end
        if (m_ack != '0 && mon_prev_ack == '0) begin
          if (ack_q.size() == 0 || rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ack_unexpected: got m_ack %0h expected none", m_ack);
          end else begin
            idx = ack_q.pop_front();
            r   = rsp_q.pop_front();
            check("m_ack", DW'(m_ack), DW'(N'(1) << idx));
            check("m_rdata", m_rdata, r.rdata);
            check("m_ret", DW'(m_ret), DW'(r.ret));
            check("s_req_drop", DW'(s_req), DW'(0));
          end
        end
        mon_prev_sreq = s_req;
        mon_prev_ack  = m_ack;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    rst       = 1'b1;
    m_req     = '0;
    m_id      = '0;
    m_fn      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    stale_ack = 1'b0;
    resp_en   = 1'b1;
    for (int i = 0; i < N; i++) cd[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_m_ack", DW'(m_ack), DW'(0));
    check("rst_s_req", DW'(s_req), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_grant_idx", DW'(grant_idx), DW'(0));
    check("rst_m_ret", DW'(m_ret), DW'(0));
    check("rst_s_wdata", s_wdata, DW'(0));
    rst = 1'b0;

    // Fairness: everyone requesting, two full rotations from pointer 0.
    batch(N'(4'hF));
    batch(N'(4'hF));

    // Single packet with known header and response.
    pay_id[2]   = 32'd5;
    pay_fn[2]   = 32'd1;
    pay_addr[2] = 32'h100;
    pay_wd[2]   = {$urandom, $urandom, $urandom, $urandom};
    plan_q.push_back('{DW'(32'hCAFE), 32'd7});
    plan(N'(4'b0100), 1'b1);
    raise(N'(4'b0100));
    step();
    check("single_latency", DW'(s_req), DW'(1));
    drain("single_done");
    check("single_ret_hold", DW'(m_ret), DW'(7));
    check("single_rdata_hold", DW'(m_rdata[31:0]), DW'(32'hCAFE));

    // Stale s_ack blocks the grant until it falls.
    rand_payload(N'(4'b0001));
    plan(N'(4'b0001), 1'b1);
    stale_ack = 1'b1;
    raise(N'(4'b0001));
    repeat (4) begin
      step();
      check("stale_block", DW'(s_req), DW'(0));
    end
    stale_ack = 1'b0;
    step();
    check("stale_release_grant", DW'(s_req), DW'(1));
    drain("stale_done");

    // Granted requester withdraws before s_ack: packet still completes.
    resp_en = 1'b0;
    rand_payload(N'(4'b1000));
    plan(N'(4'b1000), 1'b1);
    raise(N'(4'b1000));
    step();
    check("viol_grant", DW'(s_req), DW'(1));
    m_req[3] = 1'b0;
    step();
    step();
    check("viol_s_req_held", DW'(s_req), DW'(1));
    resp_en = 1'b1;
    drain("viol_done");
    check("viol_ack_clear", DW'(m_ack), DW'(0));

    // Reset in the middle of a packet aborts it.
    resp_en = 1'b0;
    rand_payload(N'(4'b0100));
    plan(N'(4'b0100), 1'b0);
    raise(N'(4'b0100));
    step();
    check("abort_grant", DW'(s_req), DW'(1));
    step();
    #2 rst = 1'b1;
    #1;
    check("abort_s_req", DW'(s_req), DW'(0));
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_m_ack", DW'(m_ack), DW'(0));
    check("abort_m_rdata", m_rdata, DW'(0));
    check("abort_m_ret", DW'(m_ret), DW'(0));
    check("abort_s_id", DW'(s_id), DW'(0));
    check("abort_s_addr", DW'(s_addr), DW'(0));
    check("abort_grant_idx", DW'(grant_idx), DW'(0));
    m_req = '0;
    @(negedge clk);
    rst     = 1'b0;
    ptr_m   = 0;
    resp_en = 1'b1;
    batch(N'(4'b0010));

    // Random batches of simultaneous requests.
    repeat (40) batch(N'($urandom_range(1, 15)));

`ifdef C2SIF_ARB_TIMEOUT_EN
    begin
      int cyc;
      resp_en = 1'b0;
      rand_payload(N'(4'b0001));
      plan(N'(4'b0001), 1'b1);
      rsp_q.push_back('{DW'(0), 32'hFFFF_FFFF});
      raise(N'(4'b0001));
      cyc = 0;
      while (m_ack == '0 && cyc < int'(TO) + 20) begin
        step();
        cyc++;
      end
      check("timeout_latency", DW'(cyc), DW'(TO + 1));
      check("timeout_err_set", DW'(timeout_err), DW'(1));
      resp_en = 1'b1;
      drain("timeout_done");
      repeat (3) batch(N'($urandom_range(1, 15)));
      check("timeout_err_sticky", DW'(timeout_err), DW'(1));
    end
`else
    check("timeout_err_tied", DW'(timeout_err), DW'(0));
`endif

    repeat (3) step();
    check("hdr_q_empty", DW'(hdr_q.size()), DW'(0));
    check("ack_q_empty", DW'(ack_q.size()), DW'(0));
    check("rsp_q_empty", DW'(rsp_q.size()), DW'(0));
    check("plan_q_empty", DW'(plan_q.size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
